d2l_receiver: RTL and testbench

D2L_RECEIVER -- requirements
Module: d2l_receiver

---
 rtl/d2l_pkg.sv | 6 +
 rtl/d2l_sync.sv | 17 +
 rtl/d2l_receiver.sv | 88 ++++++++
 tb/tb_d2l_receiver.sv | 137 +++++++++++++
 4 files changed

// File: rtl/d2l_pkg.sv
// d2l_pkg: shared state type and default sizing for the dual-lane receiver
package d2l_pkg;
  typedef enum logic {IDLE, SHIFT} state_t;
  localparam int DATA_W_DEF = 16;
  localparam int SYNC_STAGES_DEF = 2;
endpackage

// File: rtl/d2l_sync.sv
// d2l_sync: multi-flop synchronizer with a parameterized reset value
module d2l_sync #(
  parameter int STAGES = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);
  logic [STAGES-1:0] ff;
  // shift the asynchronous input through the flop chain
  always_ff @(posedge clk)
    if (rst) ff <= {STAGES{RST_VAL}};
    else ff <= {ff[STAGES-2:0], d};
  assign q = ff[STAGES-1];
endmodule

// File: rtl/d2l_receiver.sv
// d2l_receiver: dual-lane serial word receiver with valid/ready output
module d2l_receiver
  import d2l_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int SYNC_STAGES = SYNC_STAGES_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sclk,
  input  logic              CS,
  input  logic              DL1,
  input  logic              DL0,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  input  logic              rx_ready,
  output logic              overrun,
  output logic              frame_err
);
  localparam int PAIRS = DATA_W / 2;
  localparam int CW = $clog2(PAIRS);
  localparam int FW = $clog2(SYNC_STAGES + 2);
  localparam logic [CW-1:0] LAST = CW'(PAIRS - 1);
  localparam logic [FW-1:0] FLUSHED = FW'(SYNC_STAGES + 1);
  state_t state, state_n;
  logic sclk_s, cs_s, dl1_s, dl0_s, sclk_d, cs_d;
  logic [FW-1:0] flush;
  logic [CW-1:0] cnt;
  logic [DATA_W-1:0] sh, sh_n;
  logic armed, sclk_rise, cs_fall, start, stop, shift_en, word_done;
  d2l_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sclk (.clk, .rst, .d(sclk), .q(sclk_s));
  d2l_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_cs   (.clk, .rst, .d(CS),   .q(cs_s));
  d2l_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_dl1  (.clk, .rst, .d(DL1),  .q(dl1_s));
  d2l_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_dl0  (.clk, .rst, .d(DL0),  .q(dl0_s));
  // one-cycle delayed copies for edge detection
  always_ff @(posedge clk)
    if (rst) begin
      sclk_d <= 1'b0;
      cs_d   <= 1'b1;
    end else begin
      sclk_d <= sclk_s;
      cs_d   <= cs_s;
    end
  // after reset the CS chain drains its reset 1s; a low pin would look like a fall, so falls wait until the chain holds real pin data
  always_ff @(posedge clk)
    if (rst) flush <= '0;
    else if (!armed) flush <= flush + 1'b1;
  assign armed     = flush == FLUSHED;
  assign sclk_rise = sclk_s & ~sclk_d;
  assign cs_fall   = armed & cs_d & ~cs_s;
  // state register
  always_ff @(posedge clk)
    if (rst) state <= IDLE;
    else state <= state_n;
  // next state and per-cycle control strobes
  always_comb begin
    start     = state == IDLE && cs_fall;
    stop      = state == SHIFT && cs_s;
    shift_en  = state == SHIFT && !cs_s && sclk_rise;
    word_done = shift_en && cnt == LAST;
    sh_n      = {sh[DATA_W-3:0], dl1_s, dl0_s};
    state_n   = start ? SHIFT : stop ? IDLE : state;
  end
  // pair counter, shift register, output word and status pulses
  always_ff @(posedge clk)
    if (rst) begin
      cnt       <= '0;
      sh        <= '0;
      rx_data   <= '0;
      rx_valid  <= 1'b0;
      overrun   <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      overrun   <= word_done && rx_valid && !rx_ready;
      frame_err <= stop && cnt != '0;
      if (start) begin
        cnt <= '0;
        sh  <= '0;
      end else if (shift_en) begin
        cnt <= word_done ? '0 : cnt + 1'b1;
        sh  <= sh_n;
      end
      if (word_done && (!rx_valid || rx_ready)) begin
        rx_data  <= sh_n;
        rx_valid <= 1'b1;
      end else if (rx_valid && rx_ready) rx_valid <= 1'b0;
    end
endmodule

// File: tb/tb_d2l_receiver.sv
// tb_d2l_receiver: scoreboard bench driving framed dual-lane words
module tb_d2l_receiver;
  localparam int DW = 16;
  localparam int SS = 2;
  localparam int PH = 4;
  logic clk = 0, rst = 1, sclk = 0, cs = 1, dl1 = 0, dl0 = 0, rx_ready = 1;
  logic [DW-1:0] rx_data;
  logic rx_valid, overrun, frame_err;
  int total = 0, bad = 0, n_ovr = 0, n_ferr = 0;
  logic [DW-1:0] exp_q[$];
  always #5 clk = ~clk;
  d2l_receiver #(.DATA_W(DW), .SYNC_STAGES(SS)) dut (
    .clk(clk), .rst(rst), .sclk(sclk), .CS(cs), .DL1(dl1), .DL0(dl0),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .overrun(overrun), .frame_err(frame_err)
  );
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask
  // monitor: count pulses and pop the scoreboard on every accepted word
  always @(negedge clk)
    if (!rst) begin
      if (overrun) n_ovr++;
      if (frame_err) n_ferr++;
      if (rx_valid && rx_ready) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_word: got %0h want none", rx_data);
        end else check("rx_data", rx_data, exp_q.pop_front());
      end
    end
  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic pair(input logic b1, input logic b0);
    dl1 = b1;
    dl0 = b0;
    cyc(PH);
    sclk = 1;
    cyc(PH);
    sclk = 0;
  endtask
  task automatic word(input logic [DW-1:0] w);
    for (int i = DW / 2 - 1; i >= 0; i--) pair(w[2*i+1], w[2*i]);
  endtask
  task automatic frame_start();
    cs = 0;
    cyc(PH);
  endtask
  task automatic frame_end();
    cs = 1;
    cyc(3 * PH);
  endtask
  initial begin
    cyc(3);
    rst = 0;
    cyc(4);
    check("reset_valid", rx_valid, 0);
    check("reset_data", rx_data, 0);
    check("reset_overrun", overrun, 0);
    check("reset_frame_err", frame_err, 0);
    repeat (20) begin
      sclk = ~sclk;
      dl1 = 1'($urandom);
      dl0 = 1'($urandom);
      cyc(PH);
    end
    check("idle_valid", rx_valid, 0);
    check("idle_data", rx_data, 0);
    check("idle_pulses", n_ovr + n_ferr, 0);
    exp_q.push_back(16'hA5C3);
    frame_start();
    word(16'hA5C3);
    frame_end();
    check("single_drained", exp_q.size(), 0);
    check("single_valid", rx_valid, 0);
    check("single_pulses", n_ovr + n_ferr, 0);
    exp_q.push_back(16'h1234);
    exp_q.push_back(16'hFFFF);
    frame_start();
    word(16'h1234);
    word(16'hFFFF);
    frame_end();
    check("b2b_drained", exp_q.size(), 0);
    check("b2b_frame_err", n_ferr, 0);
    frame_start();
    pair(1, 0);
    pair(0, 1);
    pair(1, 1);
    frame_end();
    check("short_frame_err", n_ferr, 1);
    check("short_valid", rx_valid, 0);
    rx_ready = 0;
    exp_q.push_back(16'h00FF);
    frame_start();
    word(16'h00FF);
    word(16'hAAAA);
    frame_end();
    check("ovr_data", rx_data, 16'h00FF);
    check("ovr_valid", rx_valid, 1);
    check("ovr_count", n_ovr, 1);
    rx_ready = 1;
    cyc(2);
    check("ovr_drained", exp_q.size(), 0);
    check("ovr_valid_clear", rx_valid, 0);
    frame_start();
    pair(1, 1);
    pair(0, 0);
    pair(1, 0);
    pair(0, 1);
    rst = 1;
    cyc(1);
    rst = 0;
    pair(1, 0);
    pair(1, 1);
    pair(0, 1);
    pair(0, 0);
    frame_end();
    check("rstmid_valid", rx_valid, 0);
    check("rstmid_frame_err", n_ferr, 1);
    check("rstmid_overrun", n_ovr, 1);
    exp_q.push_back(16'h5A5A);
    frame_start();
    word(16'h5A5A);
    frame_end();
    check("after_rst_drained", exp_q.size(), 0);
    check("after_rst_frame_err", n_ferr, 1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
